// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Run/pause/lap/clear controller for a centisecond stopwatch. Debounces the
//   start/stop and lap/clear buttons, divides clk down to the centisecond tick
//   and owns the 24-bit centisecond count.
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous active-high reset
//   btn_ss      in   1   raw start/stop button (asynchronous, active-high)
//   btn_lr      in   1   raw lap/clear button (asynchronous, active-high)
//   c           out  24  live centisecond count
//   disp_c      out  24  lap value while in LAP, otherwise the live count
//   running     out  1   high in RUN or LAP
//   lap_active  out  1   high in LAP
//   ovf         out  1   one-cycle pulse when c wraps MAX_COUNT -> 0
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 500000,
    parameter int DB_CYCLES = 1000000,
    parameter int MAX_COUNT = 599999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_ss,
    input  logic        btn_lr,
    output logic [23:0] c,
    output logic [23:0] disp_c,
    output logic        running,
    output logic        lap_active,
    output logic        ovf
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [DW-1:0] DB_FULL   = DW'(DB_CYCLES);
    localparam logic [23:0]   C_MAX     = 24'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    // Bit 0 = start/stop, bit 1 = lap/clear
    logic [1:0]    btn_raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    press_r;
    logic [DW-1:0] db_cnt_r [2];

    state_t        state_r, state_nxt_s;
    logic [23:0]   c_r, c_nxt_s;
    logic [23:0]   lap_r, lap_nxt_s;
    logic [TW-1:0] tick_cnt_r, tick_cnt_nxt_s;
    logic          ovf_r, ovf_nxt_s;
    logic          running_r;
    logic          lap_active_r;
    logic          tick_s;
    logic          active_s;
    logic          ss_p_s;
    logic          lr_p_s;

    assign btn_raw_s = {btn_lr, btn_ss};
    assign ss_p_s    = press_r[0];
    assign lr_p_s    = press_r[1];

    // Synchronise buttons, count stable-high samples, emit a single press pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            press_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= {DW{1'b0}};
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                // Saturation at DB_FULL is what stops a held button repeating
                if (!sync2_r[i]) begin
                    db_cnt_r[i] <= {DW{1'b0}};
                end else if (db_cnt_r[i] != DB_FULL) begin
                    db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i];
                end
                press_r[i] <= sync2_r[i] && (db_cnt_r[i] == DB_LAST);
            end
        end
    end

    // Next-state, prescaler, counter and lap capture
    always_comb begin
        state_nxt_s    = state_r;
        c_nxt_s        = c_r;
        lap_nxt_s      = lap_r;
        tick_cnt_nxt_s = tick_cnt_r;
        tick_s         = 1'b0;
        active_s       = (state_r == RUN) || (state_r == LAP);

        // Prescaler runs only while counting; PAUSE keeps the sub-tick phase
        if (active_s) begin
            if (tick_cnt_r == TICK_LAST) begin
                tick_s         = 1'b1;
                tick_cnt_nxt_s = {TW{1'b0}};
            end else begin
                tick_cnt_nxt_s = tick_cnt_r + TW'(1);
            end
        end else if (state_r == IDLE) begin
            tick_cnt_nxt_s = {TW{1'b0}};
        end else begin
            tick_cnt_nxt_s = tick_cnt_r;
        end

        // The tick is applied before any state change in the same cycle
        if (tick_s) begin
            c_nxt_s = (c_r == C_MAX) ? 24'd0 : (c_r + 24'd1);
        end else begin
            c_nxt_s = c_r;
        end
        ovf_nxt_s = tick_s && (c_r == C_MAX);

        // Start/stop has priority over lap/clear when both pulse together
        case (state_r)
            IDLE: begin
                if (ss_p_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (ss_p_s) begin
                    state_nxt_s = PAUSE;
                end else if (lr_p_s) begin
                    state_nxt_s = LAP;
                    lap_nxt_s   = c_r;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            LAP: begin
                if (ss_p_s) begin
                    state_nxt_s = PAUSE;
                end else if (lr_p_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = LAP;
                end
            end
            PAUSE: begin
                if (ss_p_s) begin
                    state_nxt_s = RUN;
                end else if (lr_p_s) begin
                    state_nxt_s    = IDLE;
                    c_nxt_s        = 24'd0;
                    tick_cnt_nxt_s = {TW{1'b0}};
                    lap_nxt_s      = 24'd0;
                end else begin
                    state_nxt_s = PAUSE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs are registered from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            c_r          <= 24'd0;
            lap_r        <= 24'd0;
            tick_cnt_r   <= {TW{1'b0}};
            ovf_r        <= 1'b0;
            running_r    <= 1'b0;
            lap_active_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            c_r          <= c_nxt_s;
            lap_r        <= lap_nxt_s;
            tick_cnt_r   <= tick_cnt_nxt_s;
            ovf_r        <= ovf_nxt_s;
            running_r    <= (state_nxt_s == RUN) || (state_nxt_s == LAP);
            lap_active_r <= (state_nxt_s == LAP);
        end
    end

    assign c          = c_r;
    assign disp_c     = lap_active_r ? lap_r : c_r;
    assign running    = running_r;
    assign lap_active = lap_active_r;
    assign ovf        = ovf_r;

endmodule
